taxi_sfp_port_ctrl: RTL
=======================

Name: taxi_sfp_port_ctrl

Overview:
Per-cage SFP+ bring-up sequencer, instantiated once per SFP+ port next to the transceiver/PCS in the FPGA core, clocked from the 125 MHz MMCM-derived domain.
- Debounces module presence and sequences TX disable and transceiver datapath reset.
- Watches LOS and PCS block lock, drives rate-select and status LEDs.
- Retries link bring-up after faults and reports state and fault counts.

Parameters:
DEBOUNCE_CYCLES, 125000, consecutive cycles sfp_npres must be low before the module counts as present (1 ms at 125 MHz)
TX_ON_CYCLES, 125000, cycles after releasing sfp_tx_disable before releasing phy_rst
LINK_TIMEOUT_CYCLES, 12500000, maximum wait for block lock in LINK_WAIT (100 ms)
RETRY_CYCLES, 1250000, hold-off in FAULT before a retry
BLINK_CYCLES, 6250000, LED half-period; used only with the optional feature

Ports:
clk  input  1  system clock, 125 MHz
rst_n  input  1  synchronous active-low reset
cfg_port_en  input  1  port enable; 0 forces DISABLED
cfg_rate_sel  input  1  requested SFP rate select
sfp_npres  input  1  module-absent pin, async, high = absent
sfp_los  input  1  loss-of-signal pin, async, high = LOS
rx_block_lock  input  1  PCS block lock, synchronous to clk
sfp_tx_disable  output  1  SFP TX disable pin
sfp_rs  output  2  SFP RS0/RS1 pins, both equal to the registered rate
phy_rst  output  1  active-high reset to transceiver/PCS datapath
led  output  2  [0] module present, [1] link
status_state  output  3  current state encoding
status_fault_cnt  output  8  saturating fault counter
irq  output  1  one-cycle pulse on every state change

Behaviour:
- Reset values (rst_n low at a clock edge): state ABSENT; sfp_tx_disable=1, phy_rst=1, sfp_rs=0, led=0, status_fault_cnt=0, irq=0, counters=0, synchronizers=1.
- sfp_npres and sfp_los each pass through a 2-FF synchronizer reset to 1. All outputs are registered and change one cycle after the state transition.
- Single down-counter, width $clog2 of the largest parameter plus 1. It is loaded on entry to each timed state, and expiry means count==0.
- State encoding: DISABLED=0, ABSENT=1, DEBOUNCE=2, POWERUP=3, LINK_WAIT=4, UP=5, FAULT=6.
- Priority order, evaluated every cycle:
  1. cfg_port_en=0 -> DISABLED.
  2. npres_s=1 in any state other than DISABLED/ABSENT -> ABSENT.
  3. Per-state rules below.
- DISABLED: tx_disable=1, phy_rst=1. cfg_port_en=1 -> ABSENT.
- ABSENT: tx_disable=1, phy_rst=1. npres_s=0 -> DEBOUNCE, load DEBOUNCE_CYCLES-1.
- DEBOUNCE: npres_s=1 -> ABSENT. Expiry -> POWERUP, load TX_ON_CYCLES-1, tx_disable=0.
- POWERUP: tx_disable=0, phy_rst=1. Expiry -> LINK_WAIT, load LINK_TIMEOUT_CYCLES-1.
- LINK_WAIT: phy_rst=0. rx_block_lock=1 and los_s=0 -> UP. Expiry -> FAULT.
- UP: rx_block_lock=0 or los_s=1 -> FAULT.
- FAULT: tx_disable=1, phy_rst=1, load RETRY_CYCLES-1 on entry. Expiry -> POWERUP.
- Every entry into FAULT increments status_fault_cnt, saturating at 255. Clearing happens only on reset.
- sfp_rs = {2{rate_q}}, where rate_q registers cfg_rate_sel every cycle.
- A change of rate_q while in LINK_WAIT or UP forces FAULT (counted) so the link re-trains.
- irq=1 for exactly one cycle in the cycle status_state changes. Back-to-back changes give back-to-back pulses.
- led[0] = state not in {DISABLED, ABSENT, DEBOUNCE}. led[1] = (state==UP).
- Simultaneous events: cfg_port_en=0 beats npres; npres beats LOS/lock; in LINK_WAIT, lock beats timeout on the same cycle.
- Reset asserted mid-sequence returns to the reset values on the next edge, regardless of state.

Optional Feature:
SFP_PORT_CTRL_LED_BLINK_EN
- Defined: led[1] toggles every BLINK_CYCLES while in POWERUP or LINK_WAIT, is solid 1 in UP, and 0 otherwise. The blink counter is separate, reset to 0, and cleared on entry to POWERUP.
- Undefined: led[1] = (state==UP), with no blink counter in the design.

Test Plan:
All tests use DEBOUNCE=16, TX_ON=8, LINK_TIMEOUT=32, RETRY=10.
- Power-on insert: rst_n low 4 cycles, cfg_port_en=1, npres=0 held -> DEBOUNCE → POWERUP after 16 cycles; sfp_tx_disable falls; phy_rst falls 8 cycles later; lock=1 → state 5, led=2'b11, one irq per transition.
- Glitchy insert: npres low 10 cycles, high 1, low again -> returns to ABSENT; full 16-cycle debounce restarts; no POWERUP before then.
- Link timeout: lock held 0 -> FAULT after 32 cycles in LINK_WAIT, fault_cnt=1; POWERUP after 10 more cycles; 256 repeats -> fault_cnt stays 255.
- LOS in UP: sfp_los=1 pulse of 3 cycles -> FAULT 3 cycles later (2 sync + 1), tx_disable=1, phy_rst=1; retry then reaches UP once LOS clears and lock returns.
- Priority: npres=1 and cfg_port_en=0 in the same cycle while UP -> DISABLED, not ABSENT. Rate_sel toggle in UP -> sfp_rs=2'b11 next cycle, plus FAULT.
- Mid-sequence reset: rst_n low during LINK_WAIT -> next edge gives all outputs at reset values, fault_cnt=0, state=1.

Source files
------------

// File: rtl/taxi_sfp_port_ctrl.sv
// Per-cage SFP+ bring-up sequencer: presence debounce, TX enable, PCS reset, link watch and retry.
// Optional build macro SFP_PORT_CTRL_LED_BLINK_EN blinks led[1] while the link is coming up.
module taxi_sfp_port_ctrl #(
   parameter int DEBOUNCE_CYCLES     = 125000,
   parameter int TX_ON_CYCLES        = 125000,
   parameter int LINK_TIMEOUT_CYCLES = 12500000,
   parameter int RETRY_CYCLES        = 1250000,
   parameter int BLINK_CYCLES        = 6250000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cfg_port_en,
   input  logic       cfg_rate_sel,
   input  logic       sfp_npres,
   input  logic       sfp_los,
   input  logic       rx_block_lock,
   output logic       sfp_tx_disable,
   output logic [1:0] sfp_rs,
   output logic       phy_rst,
   output logic [1:0] led,
   output logic [2:0] status_state,
   output logic [7:0] status_fault_cnt,
   output logic       irq
);

   localparam int MAX_A      = (DEBOUNCE_CYCLES > TX_ON_CYCLES) ? DEBOUNCE_CYCLES : TX_ON_CYCLES;
   localparam int MAX_B      = (LINK_TIMEOUT_CYCLES > RETRY_CYCLES) ? LINK_TIMEOUT_CYCLES : RETRY_CYCLES;
   localparam int MAX_C      = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAX_CYCLES = (MAX_C > BLINK_CYCLES) ? MAX_C : BLINK_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

   typedef enum logic [2:0] {
      S_DISABLED  = 3'd0,
      S_ABSENT    = 3'd1,
      S_DEBOUNCE  = 3'd2,
      S_POWERUP   = 3'd3,
      S_LINK_WAIT = 3'd4,
      S_UP        = 3'd5,
      S_FAULT     = 3'd6
   } state_t;

   logic             npres_p0, npres_p1;
   logic             los_p0, los_p1;
   logic             rate_q;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       fault_cnt_q;
   logic             tx_disable_q, phy_rst_q, led_present_q, led_link_q, irq_q;
   logic             expired, rate_change, fault_entry;

   function automatic logic [CNT_W-1:0] load_value(input state_t s);
      case (s)
         S_DEBOUNCE:  load_value = CNT_W'(DEBOUNCE_CYCLES - 1);
         S_POWERUP:   load_value = CNT_W'(TX_ON_CYCLES - 1);
         S_LINK_WAIT: load_value = CNT_W'(LINK_TIMEOUT_CYCLES - 1);
         S_FAULT:     load_value = CNT_W'(RETRY_CYCLES - 1);
         default:     load_value = '0;
      endcase
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      sat_inc = (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign expired     = (cnt_q == '0);
   // rate_q is about to take a new value on this edge
   assign rate_change = (cfg_rate_sel != rate_q);

   always_comb begin
      state_d = state_q;
      if (!cfg_port_en) begin
         state_d = S_DISABLED;
      end else if (npres_p1 && state_q != S_DISABLED && state_q != S_ABSENT) begin
         state_d = S_ABSENT;
      end else if (rate_change && (state_q == S_LINK_WAIT || state_q == S_UP)) begin
         state_d = S_FAULT;
      end else begin
         case (state_q)
            S_DISABLED:  state_d = S_ABSENT;
            S_ABSENT:    if (!npres_p1) state_d = S_DEBOUNCE;
            S_DEBOUNCE:  if (expired) state_d = S_POWERUP;
            S_POWERUP:   if (expired) state_d = S_LINK_WAIT;
            S_LINK_WAIT: begin
               // lock wins over a timeout landing on the same cycle
               if (rx_block_lock && !los_p1) state_d = S_UP;
               else if (expired)             state_d = S_FAULT;
            end
            S_UP:        if (!rx_block_lock || los_p1) state_d = S_FAULT;
            S_FAULT:     if (expired) state_d = S_POWERUP;
            default:     state_d = S_ABSENT;
         endcase
      end

      fault_entry = (state_d == S_FAULT) && (state_q != S_FAULT);

      cnt_d = cnt_q;
      if (state_d != state_q) cnt_d = load_value(state_d);
      else if (!expired)      cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         npres_p0      <= 1'b1;
         npres_p1      <= 1'b1;
         los_p0        <= 1'b1;
         los_p1        <= 1'b1;
         rate_q        <= 1'b0;
         state_q       <= S_ABSENT;
         cnt_q         <= '0;
         fault_cnt_q   <= '0;
         tx_disable_q  <= 1'b1;
         phy_rst_q     <= 1'b1;
         led_present_q <= 1'b0;
         irq_q         <= 1'b0;
      end else begin
         npres_p0      <= sfp_npres;
         npres_p1      <= npres_p0;
         los_p0        <= sfp_los;
         los_p1        <= los_p0;
         rate_q        <= cfg_rate_sel;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         tx_disable_q  <= !(state_d inside {S_POWERUP, S_LINK_WAIT, S_UP});
         phy_rst_q     <= !(state_d inside {S_LINK_WAIT, S_UP});
         led_present_q <= !(state_d inside {S_DISABLED, S_ABSENT, S_DEBOUNCE});
         irq_q         <= (state_d != state_q);
         if (fault_entry) fault_cnt_q <= sat_inc(fault_cnt_q);
      end
   end

`ifdef SFP_PORT_CTRL_LED_BLINK_EN
   localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);

   logic [BLINK_W-1:0] blink_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         blink_cnt  <= '0;
         led_link_q <= 1'b0;
      end else if (state_d == S_UP) begin
         led_link_q <= 1'b1;
      end else if (state_d == S_POWERUP || state_d == S_LINK_WAIT) begin
         // each bring-up attempt restarts the blink phase lit
         if (state_d == S_POWERUP && state_q != S_POWERUP) begin
            blink_cnt  <= '0;
            led_link_q <= 1'b1;
         end else if (blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
            blink_cnt  <= '0;
            led_link_q <= ~led_link_q;
         end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
         end
      end else begin
         led_link_q <= 1'b0;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!rst_n) led_link_q <= 1'b0;
      else        led_link_q <= (state_d == S_UP);
   end
`endif

   assign sfp_tx_disable   = tx_disable_q;
   assign phy_rst          = phy_rst_q;
   assign sfp_rs           = {2{rate_q}};
   assign led              = {led_link_q, led_present_q};
   assign status_state     = state_q;
   assign status_fault_cnt = fault_cnt_q;
   assign irq              = irq_q;

endmodule
